mem_stage_lsu: RTL

Load/store unit for the MEM stage: consumes the access fields held in the EX/MEM pipeline register, issues one request per access on a valid/ready data bus, and waits for the response. It aligns store data and byte strobes, and sign/zero-extends load data for the MEM/WB register. While an access is outstanding it stalls the pipeline, and it holds a completed result until the pipeline advances.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/mem_stage_lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access type codes,
// FSM state enum and the misalignment predicate used when trapping is enabled.
package lsu_pkg;

  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_LW   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;
  localparam logic [2:0] LT_NONE = 3'b111;

  localparam logic [1:0] ST_SB   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SW   = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input logic is_store, input logic [2:0] lt,
                                         input logic [1:0] st, input logic [1:0] off);
    if (is_store)
      return ((st == ST_SH) && off[0]) || ((st == ST_SW) && (off != 2'b00));
    return (((lt == LT_LH) || (lt == LT_LHU)) && off[0]) || ((lt == LT_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobe/data replication and load extraction
// with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  store_type,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  load_type,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    wstrb = '0;
    wdata = '0;
    case (store_type)
      ST_SB: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{store_data[7:0]}};
      end
      ST_SH: begin
        wstrb = 4'b0011 << {st_off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      ST_SW: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  // Halfword offset uses addr[1] only, so odd halfword offsets truncate down.
  assign byte_sh = rdata >> {ld_off, 3'b000};
  assign half_sh = rdata >> {ld_off[1], 4'b0000};

  always_comb begin
    load_data = '0;
    case (load_type)
      LT_LB:   load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LT_LBU:  load_data = {24'd0, byte_sh[7:0]};
      LT_LH:   load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      LT_LHU:  load_data = {16'd0, half_sh[15:0]};
      LT_LW:   load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one valid/ready bus request per access, stall
// until complete, hold result until the pipeline advances.
// Optional misaligned-access trap selected by defining MISALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | no access in flight; request driven combinationally when access present
// REQ    | request presented, waiting for dbus_req_ready
// RSP    | load issued, waiting for dbus_rsp_valid
// DONE   | result held, stall released, waiting for pipeline_en
module mem_stage_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic        mem_memory_write,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [1:0]  mem_memory_store_type,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic        mem_misaligned,
`endif
  output logic        mem_stall,
  output logic [31:0] mem_load_data
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  ltype_q, ltype_d;
  logic        flush_q, flush_d;
  logic [31:0] load_data_q, load_data_d;
  logic        store_present, load_present, access, trap;
  logic        req_valid, req_fire, flush_seen;
  logic [3:0]  wstrb_a;
  logic [31:0] wdata_a, ld_ext;
`ifdef MISALIGN_TRAP_EN
  logic        misal_q, misal_d;
`endif

  assign store_present = mem_memory_write && (mem_memory_store_type != ST_NONE);
  assign load_present  = !store_present && (mem_memory_load_type != LT_NONE);
  assign access        = store_present || load_present;

`ifdef MISALIGN_TRAP_EN
  assign trap = access && is_misaligned(store_present, mem_memory_load_type,
                                        mem_memory_store_type, mem_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign req_valid = (state_q == S_REQ) || ((state_q == S_IDLE) && access && !trap);
  assign req_fire  = req_valid && dbus_req_ready;

  // Any change of the captured access while waiting means it was flushed upstream.
  assign flush_seen = flush_q || store_present || (mem_result != addr_q) ||
                      (mem_memory_load_type != ltype_q);

  lsu_align u_align (
    .st_off     (mem_result[1:0]),
    .store_type (store_present ? mem_memory_store_type : ST_NONE),
    .store_data (mem_op2_selected),
    .wstrb      (wstrb_a),
    .wdata      (wdata_a),
    .ld_off     (addr_q[1:0]),
    .load_type  (ltype_q),
    .rdata      (dbus_rdata),
    .load_data  (ld_ext)
  );

  // Outputs are forced to their reset values while rst is held low.
  assign dbus_req_valid = rst && req_valid;
  assign dbus_addr      = dbus_req_valid ? {mem_result[31:2], 2'b00} : '0;
  assign dbus_we        = dbus_req_valid && store_present;
  assign dbus_wstrb     = dbus_req_valid ? wstrb_a : '0;
  assign dbus_wdata     = dbus_req_valid ? wdata_a : '0;
  assign mem_stall      = access && (state_q != S_DONE);
  assign mem_load_data  = load_data_q;
`ifdef MISALIGN_TRAP_EN
  assign mem_misaligned = misal_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ltype_d     = ltype_q;
    flush_d     = flush_q;
    load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
    misal_d     = misal_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (access) state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
        if (trap) begin
          state_d     = S_DONE;
          load_data_d = '0;
          misal_d     = 1'b1;
        end
`endif
      end
      S_REQ: ;
      S_RSP: begin
        if (dbus_rsp_valid) begin
          state_d = flush_seen ? S_IDLE : S_DONE;
          if (!flush_seen) load_data_d = ld_ext;
        end else begin
          flush_d = flush_seen;
        end
      end
      S_DONE: begin
        if (pipeline_en) begin
          state_d = S_IDLE;
`ifdef MISALIGN_TRAP_EN
          misal_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (req_fire) begin
      addr_d  = mem_result;
      ltype_d = load_present ? mem_memory_load_type : LT_NONE;
      flush_d = 1'b0;
      state_d = store_present ? S_DONE : S_RSP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ltype_q     <= LT_NONE;
      flush_q     <= 1'b0;
      load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misal_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ltype_q     <= ltype_d;
      flush_q     <= flush_d;
      load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
      misal_q     <= misal_d;
`endif
    end
  end

endmodule
